// File: rtl/writeback_regfile.sv
// Write-back stage and 32-entry architectural register file.
// Selects the write-back value, commits it on the clock edge and serves two bypassed read ports.
module writeback_regfile #(
  parameter int unsigned   N       = 32,
  parameter logic [N-1:0]  SP_INIT = 32'h7FFF_EFFC,
  parameter logic [N-1:0]  GP_INIT = 32'h1000_8000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] ALU_result_in,
  input  logic [N-1:0] Read_data_in,
  input  logic [N-1:0] PC_4_in,
  input  logic [4:0]   WriteRegister_in,
  input  logic         MemtoReg_in,
  input  logic         Jal_in,
  input  logic         RegWrite_in,
  input  logic [4:0]   Read_reg1,
  input  logic [4:0]   Read_reg2,
  output logic [N-1:0] Read_data1,
  output logic [N-1:0] Read_data2,
  output logic [N-1:0] WB_data,
  output logic [4:0]   WB_reg,
  output logic         WB_valid
);

  localparam logic [4:0] GP_IDX = 5'd28;
  localparam logic [4:0] SP_IDX = 5'd29;

  logic [N-1:0] regs [0:31];

  // Jal wins over MemtoReg so a jal never picks up stale load data.
  always_comb begin
    WB_data = ALU_result_in;
    if (Jal_in)           WB_data = PC_4_in;
    else if (MemtoReg_in) WB_data = Read_data_in;
  end

  assign WB_reg   = WriteRegister_in;
  assign WB_valid = RegWrite_in && (WriteRegister_in != 5'd0);

  // NOTE: the array is reset explicitly because $gp/$sp need non-zero values; this
  // keeps it out of block RAM, which is fine for a 32-entry flop-based file.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        // NOTE: non-blocking assignments for all sequential state, so later reads in
        // this block and other processes see the pre-edge values.
        regs[i] <= '0;
      end
      regs[GP_IDX] <= GP_INIT;
      regs[SP_IDX] <= SP_INIT;
    end else if (WB_valid) begin
      regs[WriteRegister_in] <= WB_data;
    end
  end

  // $zero is forced on read, so entry 0 never matters even if it held garbage.
  always_comb begin
    Read_data1 = regs[Read_reg1];
    if (Read_reg1 == 5'd0)                         Read_data1 = '0;
    else if (WB_valid && (WB_reg == Read_reg1))    Read_data1 = WB_data;
  end

  always_comb begin
    Read_data2 = regs[Read_reg2];
    if (Read_reg2 == 5'd0)                         Read_data2 = '0;
    else if (WB_valid && (WB_reg == Read_reg2))    Read_data2 = WB_data;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back stage plus architectural register file for the 5-stage pipelined MIPS core. Consumes the registered MEM/WB outputs, selects the write-back value (memory read data, ALU result or return address), commits it to a 32 x N register file on the clock edge, and serves the two ID-stage read ports with write-before-read bypass. It is the consuming end of the MEM/WB interface and the producing end of the WB forwarding path.

## Interface
- N, 32, data width of every register and data port
- SP_INIT, 32'h7FFF_EFFC, reset value of $sp (register 29)
- GP_INIT, 32'h1000_8000, reset value of $gp (register 28)

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  reset, synchronous, active-low
- ALU_result_in  in  N  ALU result from MEM/WB
- Read_data_in  in  N  data-memory read data from MEM/WB
- PC_4_in  in  N  PC+4 from MEM/WB, return address for jal
- WriteRegister_in  in  5  destination register from MEM/WB
- MemtoReg_in  in  1  1 selects Read_data_in
- Jal_in  in  1  1 selects PC_4_in (takes priority over MemtoReg_in)
- RegWrite_in  in  1  write enable from MEM/WB
- Read_reg1, Read_reg2  in  5 each  ID-stage read addresses
- Read_data1, Read_data2  out  N each  ID-stage read data
- WB_data  out  N  selected write-back value (to forwarding muxes)
- WB_reg  out  5  WriteRegister_in passthrough
- WB_valid  out  1  RegWrite_in && WriteRegister_in != 0

## Operation
- Write-back select (combinational): Jal_in ? PC_4_in : MemtoReg_in ? Read_data_in : ALU_result_in.
- Commit: on rising clk with reset==1 and WB_valid==1, reg[WriteRegister_in] <= WB_data. No other register changes.
- Register 0: never written; always reads 0, including through bypass.
- Reads (combinational): Read_dataK = 0 if Read_regK==0; else WB_data if WB_valid && WB_reg==Read_regK; else reg[Read_regK]. Both ports independent; both may hit bypass simultaneously.
- Reset: on rising clk with reset==0, every register <= 0 except reg[28] <= GP_INIT, reg[29] <= SP_INIT. Reset has priority over a concurrent write; the write is dropped.
- No enable/stall input: the block commits every cycle RegWrite_in is asserted; pipeline bubbles arrive as RegWrite_in==0.
- Width: all data paths exactly N bits; no extension or truncation.

## Timing
- Write latency: value presented with WB_valid in cycle t is stored at edge ending cycle t; visible via bypass in cycle t, via storage from cycle t+1.
- Read latency: zero cycles (purely combinational from Read_regK, MEM/WB inputs and storage).
- WB_data/WB_reg/WB_valid: combinational, zero latency.
- Reset values after the reset edge: Read_dataK = 0 for all addresses except 28 -> GP_INIT, 29 -> SP_INIT; WB_* outputs follow inputs (not registered, not forced by reset).
- Reset asserted mid-stream: the cycle's write is lost; after reset deasserts, the first committed write is the one present at the first edge with reset==1.
- Back-to-back writes to the same register: last edge wins; bypass always reflects the current-cycle input.

## Test plan
- Reset: hold reset=0 one edge, release -> read 28 = 32'h1000_8000, 29 = 32'h7FFF_EFFC, 5 = 0, 31 = 0.
- Select: RegWrite=1, dest 8, ALU=32'h1234, Read_data=32'hABCD, PC_4=32'h0040_0008; MemtoReg=0,Jal=0 -> $8=32'h1234; MemtoReg=1 -> 32'hABCD; Jal=1,MemtoReg=1 -> 32'h0040_0008.
- Bypass: write dest 9 = 32'hDEAD_BEEF, Read_reg1=Read_reg2=9 same cycle -> both read DEAD_BEEF before edge; old value not visible; after edge storage holds it with RegWrite=0.
- $zero: RegWrite=1, dest 0, ALU=32'hFFFF_FFFF -> WB_valid=0, Read_data1(0)=0 same cycle and next.
- Disable: RegWrite=0, dest 10, ALU=32'h55 -> $10 unchanged, no bypass hit.
- Reset vs write: reset=0 with RegWrite=1, dest 29, ALU=32'h1 on same edge -> $29 = SP_INIT after edge.
